// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU op codes, muldiv op codes
// and sequencer state encodings.
package alu_muldiv_seq_pkg;

    localparam int ALU_CONTROL_WIDTH = 4;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB = 4'b0110;

    localparam int MULDIV_OP_WIDTH = 2;
    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_MUL   = 2'b00;
    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_MULHU = 2'b01;
    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_DIVU  = 2'b10;
    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_REMU  = 2'b11;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    // DIVU/REMU share the restoring-divide datapath; MUL/MULHU share shift-add.
    function automatic logic is_div(input logic [MULDIV_OP_WIDTH-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M unsigned MUL/MULHU/DIVU/REMU sequencer driving the shared EX ALU.
// Optional macro MULDIV_DIV0_FAST_EN: divide-by-zero skips the iterative phase.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [MULDIV_OP_WIDTH-1:0]   in_op,
    input  logic [DATA_WIDTH-1:0]        in_rs1,
    input  logic [DATA_WIDTH-1:0]        in_rs2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_result,
    output logic                         busy,
    output logic [DATA_WIDTH-1:0]        alu_input_data_1,
    output logic [DATA_WIDTH-1:0]        alu_input_data_2,
    output logic [ALU_CONTROL_WIDTH-1:0] alu_control,
    input  logic [DATA_WIDTH-1:0]        alu_output_data
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    seq_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [DATA_WIDTH-1:0]      hi_q, lo_q, m_q;
    logic [MULDIV_OP_WIDTH-1:0] op_q;

    logic                  accept, last, div0_fast;
    logic [DATA_WIDTH-1:0] mul_sum, div_rs;
    logic                  mul_carry, div_rc, div_ge;

`ifdef MULDIV_DIV0_FAST_EN
    assign div0_fast = is_div(in_op) && (in_rs2 == '0);
`else
    assign div0_fast = 1'b0;
`endif

    assign accept    = (state_q == SEQ_IDLE) && in_valid && !flush;
    assign last      = (cnt_q == CNT_LAST);
    assign in_ready  = (state_q == SEQ_IDLE);
    assign busy      = (state_q != SEQ_IDLE);
    assign out_valid = (state_q == SEQ_DONE);
    // Odd op codes (MULHU, REMU) return the high/remainder register.
    assign out_result = op_q[0] ? hi_q : lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = SEQ_IDLE;
        end else begin
            case (state_q)
                SEQ_IDLE: if (in_valid) state_d = div0_fast ? SEQ_DONE : SEQ_RUN;
                SEQ_RUN:  if (last)     state_d = SEQ_DONE;
                SEQ_DONE: if (out_ready) state_d = SEQ_IDLE;
                default:  state_d = SEQ_IDLE;
            endcase
        end
    end

    // Per-iteration operands; the ALU does the wide add/sub, carry and borrow come from compares.
    always_comb begin
        div_rc           = hi_q[DATA_WIDTH-1];
        div_rs           = {hi_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]};
        div_ge           = div_rc | (div_rs >= m_q);
        mul_sum          = lo_q[0] ? alu_output_data : hi_q;
        mul_carry        = lo_q[0] & (mul_sum < hi_q);
        alu_input_data_1 = '0;
        alu_input_data_2 = '0;
        alu_control      = ALU_ADD;
        if (state_q == SEQ_RUN) begin
            alu_input_data_2 = m_q;
            if (is_div(op_q)) begin
                alu_input_data_1 = div_rs;
                alu_control      = ALU_SUB;
            end else begin
                alu_input_data_1 = hi_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            op_q  <= MULDIV_MUL;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            op_q  <= in_op;
            m_q   <= in_rs2;
            if (div0_fast) begin
                hi_q <= in_rs1;
                lo_q <= '1;
            end else begin
                hi_q <= '0;
                lo_q <= in_rs1;
            end
        end else if (state_q == SEQ_RUN) begin
            cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
            if (is_div(op_q)) begin
                hi_q <= div_ge ? alu_output_data : div_rs;
                lo_q <= {lo_q[DATA_WIDTH-2:0], div_ge};
            end else begin
                hi_q <= {mul_carry, mul_sum[DATA_WIDTH-1:1]};
                lo_q <= {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with a behavioural ALU and arithmetic reference model.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0] in_op;
  logic [W-1:0] in_rs1, in_rs2, out_result;
  logic [W-1:0] alu_input_data_1, alu_input_data_2, alu_output_data;
  logic [ALU_CONTROL_WIDTH-1:0] alu_control;

  int n_checks = 0;
  int n_fail = 0;
`ifdef MULDIV_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = W + 1;
`endif

  always #5 clk = ~clk;

  // Shared EX ALU stand-in.
  assign alu_output_data = (alu_control == ALU_SUB) ? alu_input_data_1 - alu_input_data_2
                                                    : alu_input_data_1 + alu_input_data_2;

  alu_muldiv_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy),
    .alu_input_data_1(alu_input_data_1), .alu_input_data_2(alu_input_data_2),
    .alu_control(alu_control), .alu_output_data(alu_output_data)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'b00: return p[W-1:0];
      2'b01: return p[2*W-1:W];
      2'b10: return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Presents one request at a negedge; accept happens on the following posedge.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; returns cycles since accept (1 already elapsed on return of start_op).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat);
    int lat;
    start_op(op, a, b);
    wait_valid(lat);
    check({tag, "_result"}, out_result, ref_result(op, a, b));
    if (exp_lat > 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    drain(tag);
  endtask

  initial begin
    int lat;
    logic [W-1:0] held;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_rs1 = '0; in_rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_alu_ctl", 32'(alu_control), 32'(ALU_ADD));

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, W + 1);
    check("mul_7x6_const", ref_result(2'b00, 32'd7, 32'd6), 32'h2A);
    run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1);
    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, W + 1);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, W + 1);
    run_op("divu_rc", 2'b10, 32'h8000_0001, 32'd3, W + 1);
    run_op("divu_by0", 2'b10, 32'd5, 32'd0, DIV0_LAT);
    run_op("remu_by0", 2'b11, 32'd5, 32'd0, DIV0_LAT);

    // Backpressure: result and handshake state held while out_ready is low.
    start_op(2'b00, 32'd1234, 32'd5678);
    wait_valid(lat);
    held = ref_result(2'b00, 32'd1234, 32'd5678);
    for (int i = 0; i < 5; i++) begin
      check("bp_result", out_result, held);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    drain("bp");

    // Flush mid-run: no result ever appears.
    start_op(2'b00, 32'd99, 32'd77);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) lat++;
      @(posedge clk);
      @(negedge clk);
    end
    check("flush_no_valid", 32'(lat), 32'd0);
    run_op("mul_3x4", 2'b00, 32'd3, 32'd4, W + 1);

    // Flush in IDLE with a same-cycle request: request dropped.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd2; in_rs2 = 32'd2;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_busy", {31'b0, busy}, 32'd0);

    // Reset mid-run returns every output to its reset value.
    start_op(2'b11, 32'hDEAD_BEEF, 32'd13);
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_alu1", alu_input_data_1, 32'd0);
    check("rst_alu2", alu_input_data_2, 32'd0);
    check("rst_alu_ctl", 32'(alu_control), 32'(ALU_ADD));

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 15));
        1: rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, ((rop[1] && rb == 0) ? DIV0_LAT : W + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
